// File: rtl/conv_pkg.sv
// Shared definitions for the convolution pipeline: default geometry, the
// collector FSM encoding and a constant-safe clog2 helper.
package conv_pkg;

    localparam int DW_DEF    = 12;
    localparam int IMG_W_DEF = 16;
    localparam int IMG_H_DEF = 16;
    localparam int K_DEF     = 5;
    localparam int LAT_DEF   = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Never returns less than 1 so degenerate sizes still give a legal width.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/conv_frame_ram.sv
// Frame store for the collector: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module conv_frame_ram #(
    parameter int DW    = 12,
    parameter int DEPTH = 144,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);

    logic [DW-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
            end
        end
    end

endmodule

// File: rtl/conv_out_collector.sv
// Collects buffer_2d results for the valid (non-border) window positions into a frame store.
// Optional COLLECT_CHKSUM_EN adds a running 16-bit sum of every stored sample on port chksum.
module conv_out_collector
    import conv_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int K     = K_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int OUT_W = IMG_W - K + 1,
    parameter int OUT_H = IMG_H - K + 1,
    parameter int AW    = clog2(OUT_W * OUT_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    input  logic [DW-1:0] d_in,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
`ifdef COLLECT_CHKSUM_EN
    output logic [15:0]   chksum,
`endif
    output logic          done
);

    localparam int DEPTH = OUT_W * OUT_H;
    localparam int CW    = clog2(IMG_W);
    localparam int RW    = clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST_VALID = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST_VALID = RW'(K - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          en_d;
    logic          sample;
    logic          last_sample;
    logic          in_window;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (start) begin
                    state_next = CAPTURE;
                end else if (sample && last_sample) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) state_next = CAPTURE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CAPTURE);
        done = (state == DONE);
    end

    // en_d realigns the strobe with buffer_2d's output; it only advances while capturing.
    generate
        if (LAT == 0) begin : g_no_delay
            assign en_d = en;
        end else begin : g_delay
            logic [LAT-1:0] en_pipe;
            logic [LAT:0]   en_shifted;

            assign en_shifted = {en_pipe, en};
            assign en_d       = en_pipe[LAT-1];

            always_ff @(posedge clk) begin
                if (rst || start) begin
                    en_pipe <= '0;
                end else if (state == CAPTURE) begin
                    en_pipe <= en_shifted[LAT-1:0];
                end
            end
        end
    endgenerate

    // A start in CAPTURE restarts the frame, so that cycle's sample is not taken.
    assign sample      = (state == CAPTURE) && en_d && !start;
    assign last_sample = (row == ROW_LAST) && (col == COL_LAST);
    assign in_window   = (row >= ROW_FIRST_VALID) && (col >= COL_FIRST_VALID);
    assign wr_en       = sample && in_window;

    assign out_col = col - COL_FIRST_VALID;
    assign out_row = row - ROW_FIRST_VALID;

    always_comb begin
        wr_addr = AW'((int'(out_row) * OUT_W) + int'(out_col));
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            col <= '0;
            row <= '0;
        end else if (sample) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

`ifdef COLLECT_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || start) begin
            chksum <= '0;
        end else if (wr_en) begin
            chksum <= chksum + 16'(d_in);
        end
    end
`endif

    conv_frame_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (d_in),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule
